// File: rtl/i2s_frame_scheduler_if.sv
// rtl/i2s_frame_scheduler_if.sv - sample-pair stream between USB side and the I2S frame scheduler
interface i2s_frame_scheduler_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_left;
    logic [31:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_frame_scheduler.sv
// rtl/i2s_frame_scheduler.sv - I2S frame sequencer: bclk/ws generation, pair fetch, load/shift strobes
// Optional macro I2S_LEFT_JUSTIFIED_EN selects left-justified ws timing instead of the I2S one-bit delay.
module i2s_frame_scheduler #(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [3:0]             sample_size,
    i2s_frame_scheduler_if.slave   s_if,
    output logic                   bclk,
    output logic                   ws,
    output logic                   load,
    output logic                   shift,
    output logic [31:0]            par_word,
    output logic                   underrun,
    input  logic                   underrun_clr,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, PRIME, LEFT, RIGHT} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(SLOT_BITS - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic        bclk_q, bclk_d;
    logic        ws_q, ws_d;
    logic        load_q, load_d;
    logic        shift_q, shift_d;
    logic [31:0] par_word_q, par_word_d;
    logic        underrun_q, underrun_d;
    logic        busy_q, busy_d;
    logic        s_ready_q, s_ready_d;
    logic        buf_full_q, buf_full_d;
    logic [31:0] buf_left_q, buf_left_d;
    logic [31:0] buf_right_q, buf_right_d;
    logic [31:0] right_word_q, right_word_d;
    logic        wrap, fall, underrun_set;

    // MSB-justify a right-justified sample; unknown size codes fall back to 16 bits.
    function automatic logic [31:0] justify(input logic [31:0] smp, input logic [3:0] code);
        case (code)
            4'd0:    justify = smp << 24;
            4'd1:    justify = smp << 20;
            4'd3:    justify = smp << 16;
            4'd5:    justify = smp;
            default: justify = smp << 16;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_idx_d    = bit_idx_q;
        bclk_d       = bclk_q;
        ws_d         = ws_q;
        load_d       = 1'b0;
        shift_d      = 1'b0;
        par_word_d   = par_word_q;
        buf_full_d   = buf_full_q;
        buf_left_d   = buf_left_q;
        buf_right_d  = buf_right_q;
        right_word_d = right_word_q;
        underrun_set = 1'b0;

        wrap = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
        fall = wrap && bclk_q;

        if (state_q != IDLE) begin
            div_cnt_d = wrap ? 8'd0 : div_cnt_q + 8'd1;
            if (wrap) begin
                bclk_d = ~bclk_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fall && buf_full_q) begin
                    state_d   = LEFT;
                    bit_idx_d = 5'd0;
                end
            end
            LEFT, RIGHT: begin
                if (fall) begin
                    bit_idx_d = (bit_idx_q == BIT_LAST) ? 5'd0 : bit_idx_q + 5'd1;
                    if (bit_idx_q == 5'd0) begin
                        load_d = 1'b1;
`ifdef I2S_LEFT_JUSTIFIED_EN
                        ws_d = (state_q == RIGHT);
`endif
                        if (state_q == LEFT) begin
                            // Both words of the frame are justified now so one size applies to the pair.
                            if (buf_full_q) begin
                                par_word_d   = justify(buf_left_q, sample_size);
                                right_word_d = justify(buf_right_q, sample_size);
                                buf_full_d   = 1'b0;
                            end else begin
                                par_word_d   = 32'd0;
                                right_word_d = 32'd0;
                                underrun_set = 1'b1;
                            end
                        end else begin
                            par_word_d = right_word_q;
                        end
                    end else begin
                        shift_d = 1'b1;
                    end
                    if (bit_idx_q == BIT_LAST) begin
                        if (state_q == LEFT) begin
                            state_d = RIGHT;
`ifndef I2S_LEFT_JUSTIFIED_EN
                            ws_d = 1'b1;
`endif
                        end else begin
                            state_d = enable ? LEFT : IDLE;
`ifndef I2S_LEFT_JUSTIFIED_EN
                            ws_d = 1'b0;
`endif
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture is evaluated after the consume above so a same-cycle pair leaves the buffer full.
        if (s_if.s_valid && s_ready_q) begin
            buf_full_d  = 1'b1;
            buf_left_d  = s_if.s_left;
            buf_right_d = s_if.s_right;
        end

        if (state_d == IDLE) begin
            div_cnt_d  = 8'd0;
            bit_idx_d  = 5'd0;
            bclk_d     = 1'b0;
            ws_d       = 1'b0;
            buf_full_d = 1'b0;
        end

        busy_d     = (state_d != IDLE);
        s_ready_d  = busy_d && !buf_full_d && enable;
        underrun_d = underrun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_cnt_q    <= 8'd0;
            bit_idx_q    <= 5'd0;
            bclk_q       <= 1'b0;
            ws_q         <= 1'b0;
            load_q       <= 1'b0;
            shift_q      <= 1'b0;
            par_word_q   <= 32'd0;
            underrun_q   <= 1'b0;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_left_q   <= 32'd0;
            buf_right_q  <= 32'd0;
            right_word_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_idx_q    <= bit_idx_d;
            bclk_q       <= bclk_d;
            ws_q         <= ws_d;
            load_q       <= load_d;
            shift_q      <= shift_d;
            par_word_q   <= par_word_d;
            underrun_q   <= underrun_d;
            busy_q       <= busy_d;
            s_ready_q    <= s_ready_d;
            buf_full_q   <= buf_full_d;
            buf_left_q   <= buf_left_d;
            buf_right_q  <= buf_right_d;
            right_word_q <= right_word_d;
        end
    end

    assign bclk        = bclk_q;
    assign ws          = ws_q;
    assign load        = load_q;
    assign shift       = shift_q;
    assign par_word    = par_word_q;
    assign underrun    = underrun_q;
    assign busy        = busy_q;
    assign s_if.s_ready = s_ready_q;
endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// tb/tb_i2s_frame_scheduler.sv - scoreboard bench for i2s_frame_scheduler with randomized sample pairs
module tb_i2s_frame_scheduler;
    localparam int CLK_DIV   = 2;
    localparam int SLOT_BITS = 32;
    localparam int SLOT_CLKS = 2 * CLK_DIV * SLOT_BITS;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  sample_size = 4'd0;
    logic        underrun_clr = 1'b0;
    logic        bclk, ws, load, shift, underrun, busy;
    logic [31:0] par_word;

    i2s_frame_scheduler_if s_if ();

    i2s_frame_scheduler #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_size(sample_size), .s_if(s_if),
        .bclk(bclk), .ws(ws), .load(load), .shift(shift), .par_word(par_word),
        .underrun(underrun), .underrun_clr(underrun_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    pair_t exp_q[$];
    bit    mon_en = 1'b0;
    int    clr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] just(input logic [31:0] s, input logic [3:0] code);
        int n;
        n = (code == 4'd0) ? 8 : (code == 4'd1) ? 12 : (code == 4'd5) ? 32 : 16;
        return s << (32 - n);
    endfunction

    // Monitor: checks strobes, slot timing, ws placement and words against the scoreboard.
    logic        prev_bclk = 1'b0, prev_ws = 1'b0, prev_busy = 1'b0;
    int          cyc = 0, last_load_cyc = 0, shift_cnt = 0, seen_clr = 0;
    bit          have_load = 1'b0, last_was_right = 1'b0, exp_under = 1'b0;
    logic [31:0] exp_right = 32'd0;
    pair_t       mp;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (clr_cnt != seen_clr) begin
                    exp_under = 1'b0;
                    seen_clr  = clr_cnt;
                end
                if (!busy) begin
                    chk("idle_bclk_low", bclk, 0);
                    chk("idle_sready_low", s_if.s_ready, 0);
                end
                if (load || shift) begin
                    chk("strobe_on_bclk_fall", {bclk, prev_bclk}, 2'b01);
                    chk("single_strobe", load & shift, 0);
                end
                if (shift) shift_cnt++;
                if (ws !== prev_ws) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
                    if (busy) chk("ws_edge_with_msb", load, 1);
                    else chk("ws_fall_at_idle", shift, 1);
`else
                    chk("ws_edge_one_bclk_early", {shift, load, 5'(shift_cnt)}, {1'b1, 1'b0, 5'(SLOT_BITS - 1)});
`endif
                end
                if (load) begin
                    if (have_load) begin
                        chk("shifts_per_slot", shift_cnt, SLOT_BITS - 1);
                        chk("slot_period_clks", cyc - last_load_cyc, SLOT_CLKS);
                        chk("ws_alternates", ws, !last_was_right);
                    end else begin
                        chk("first_slot_is_left", ws, 0);
                    end
                    if (!ws) begin
                        if (exp_q.size() > 0) begin
                            mp = exp_q.pop_front();
                            chk("left_word", par_word, mp.l);
                            exp_right = mp.r;
                        end else begin
                            chk("underrun_left_zero", par_word, 0);
                            exp_under = 1'b1;
                            exp_right = 32'd0;
                        end
                        chk("underrun_flag", underrun, exp_under);
                    end else begin
                        chk("right_word", par_word, exp_right);
                    end
                    have_load      = 1'b1;
                    last_load_cyc  = cyc;
                    shift_cnt      = 0;
                    last_was_right = ws;
                end
                if (prev_busy && !busy) begin
                    chk("idle_after_full_slot", shift_cnt, SLOT_BITS - 1);
                    chk("idle_after_right", last_was_right, 1);
                    have_load = 1'b0;
                    shift_cnt = 0;
                end
            end
            prev_bclk = bclk;
            prev_ws   = ws;
            prev_busy = busy;
        end
    end

    task automatic present(input logic [31:0] l, input logic [31:0] r, input logic [3:0] size);
        pair_t p;
        bit    done;
        done = 1'b0;
        sample_size   = size;
        s_if.s_left   = l;
        s_if.s_right  = r;
        s_if.s_valid  = 1'b1;
        for (int i = 0; i < 4 * SLOT_CLKS && !done; i++) begin
            if (s_if.s_ready) begin
                p.l = just(l, size);
                p.r = just(r, size);
                exp_q.push_back(p);
                done = 1'b1;
            end
            @(negedge clk);
        end
        s_if.s_valid = 1'b0;
        if (!done) chk("handshake_timeout", 0, 1);
    endtask

    task automatic wait_load(input bit right);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * SLOT_CLKS && !seen; i++) begin
            @(negedge clk);
            if (load && (ws == right)) seen = 1'b1;
        end
        if (!seen) chk("load_timeout", 0, 1);
    endtask

    task automatic clear_underrun();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        clr_cnt++;
        chk("underrun_cleared", underrun, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bclk"}, bclk, 0);
        chk({tag, "_ws"}, ws, 0);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_shift"}, shift, 0);
        chk({tag, "_par_word"}, par_word, 0);
        chk({tag, "_s_ready"}, s_if.s_ready, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen;
        s_if.s_valid = 1'b0;
        s_if.s_left  = 32'd0;
        s_if.s_right = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        enable = 1'b1;
        present(32'h0000ABCD, 32'h00001234, 4'd3);
        wait_load(1'b0);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        present(32'h000000A5, $urandom, 4'd0);
        wait_load(1'b0);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        present($urandom, $urandom, 4'd7);
        wait_load(1'b0);
        wait_load(1'b0);
        repeat (10) @(negedge clk);
        chk("underrun_set", underrun, 1);
        clear_underrun();
        present($urandom, $urandom, 4'd1);

        for (int f = 0; f < 12; f++) begin
            wait_load(1'b0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            if (underrun && $urandom_range(0, 1) == 0) clear_underrun();
            if ($urandom_range(0, 4) != 0)
                present($urandom, $urandom, 4'($urandom_range(0, 15)));
        end

        wait_load(1'b0);
        cnt = 0;
        for (int i = 0; i < SLOT_CLKS && cnt < 5; i++) begin
            @(negedge clk);
            if (shift) cnt++;
        end
        chk("reached_left_bit5", cnt, 5);
        enable = 1'b0;
        @(negedge clk);
        chk("sready_drops_after_enable", s_if.s_ready, 0);
        seen = 1'b0;
        for (int i = 0; i < 3 * SLOT_CLKS && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        chk("reached_idle", seen, 1);
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_if.s_ready, 0);
        chk("queue_drained", exp_q.size(), 0);

        enable = 1'b1;
        present($urandom, $urandom, 4'd5);
        wait_load(1'b1);
        repeat (10) @(negedge clk);
        chk("busy_mid_right", busy, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Sequences the I2S serializer datapath. Generates the bit clock (bclk) and word select (ws).
- Fetches stereo sample pairs from the USB-side stream through a valid/ready handshake, one pair per frame.
- Issues one-cycle load/shift strobes and an MSB-justified 32-bit parallel word to the downstream shift register, once per channel slot.
- Detects and flags stream underruns; frame timing never stalls.

Parameters:
- CLK_DIV, 4, clk cycles per bclk half-period; legal range 1..255.
- SLOT_BITS, 32, bclk periods per channel slot; legal range 8..32.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run request; level-sensitive.
- sample_size  in  4  0=8b, 1=12b, 3=16b, 5=32b; any other code is treated as 16b.
- s_valid  in  1  upstream sample pair valid.
- s_ready  out  1  scheduler can accept a pair.
- s_left  in  32  left sample, right-justified (LSB at bit 0).
- s_right  in  32  right sample, right-justified.
- bclk  out  1  serial bit clock.
- ws  out  1  word select; 0=left, 1=right.
- load  out  1  one-cycle strobe: datapath loads par_word, drives its MSB.
- shift  out  1  one-cycle strobe: datapath shifts left by 1, drives its next MSB.
- par_word  out  32  MSB-justified sample, zero-padded below; valid when load=1.
- underrun  out  1  sticky flag, set when a frame starts with no sample buffered.
- underrun_clr  in  1  clears underrun.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Reset values: bclk=0, ws=0, load=0, shift=0, par_word=0, s_ready=0, underrun=0, busy=0. The hold buffer is emptied, the state is IDLE, and the divider and slot counters are 0.
- States: IDLE, PRIME, LEFT, RIGHT.
- IDLE: divider stopped, bclk=0, ws=0. enable=1 → PRIME on the next clk.
- PRIME: divider runs. Stay in PRIME until the hold buffer is full, then go to LEFT at the next fall event.
- Divider: div_cnt counts 0..CLK_DIV-1; at wrap, bclk toggles. A fall event is the cycle where the wrap occurs with bclk=1. On that edge, bclk<=0 and that event's strobe is asserted; the strobe lasts exactly one clk.
- Slot counter bit_idx runs 0..SLOT_BITS-1 and advances on each fall event.
  - bit_idx=0: load=1.
  - bit_idx=1..SLOT_BITS-1: shift=1.
- LEFT, bit_idx=0:
  - If the buffer is full: par_word = left sample, and the buffer is consumed.
  - If the buffer is empty: par_word=0, underrun<=1, and the RIGHT slot also loads 0.
- sample_size is latched at LEFT bit_idx=0 and used for both slots of that frame.
- Justification: par_word = sample << (32-N); bits below N are zero. If N > SLOT_BITS, the datapath's truncation of the LSBs is accepted.
- LEFT, bit_idx=SLOT_BITS-1 → RIGHT. RIGHT, bit_idx=SLOT_BITS-1 → LEFT, or → IDLE if enable=0.
- ws (I2S one-bit delay):
  - ws<=1 at the fall event of LEFT bit_idx=SLOT_BITS-1.
  - ws<=0 at the fall event of RIGHT bit_idx=SLOT_BITS-1.
- Hold buffer (one pair deep):
  - s_ready = busy & buffer empty & enable.
  - A pair is captured when s_valid & s_ready.
  - Capture and consume in the same cycle: consume happens first, then capture, so the buffer ends full.
- enable drop mid-frame: s_ready drops next cycle. The current frame completes through the last RIGHT bit, then IDLE. A buffered pair is discarded on entering IDLE.
- underrun_clr and a new underrun in the same cycle: set wins.
- rst mid-frame: immediate return to reset values; no partial frame completes.

Optional Feature:
- Macro I2S_LEFT_JUSTIFIED_EN.
  - Defined: left-justified format. ws toggles at the bit_idx=0 fall event of each slot (ws<=0 at LEFT load, ws<=1 at RIGHT load), aligned with the MSB.
  - Undefined: standard I2S one-bit delay, as specified in Behaviour.

Test Plan:
- Reset with CLK_DIV=2, SLOT_BITS=32 → all outputs 0; bclk stays 0 while enable=0.
- Set enable=1, sample_size=3, and present s_left=0x0000ABCD, s_right=0x00001234 → par_word=0xABCD0000 on the LEFT load and 0x12340000 on the RIGHT load. Exactly 31 shift strobes per slot. bclk period = 4 clk.
- Check ws against bit_idx → ws rises 1 bclk before the RIGHT MSB and falls 1 bclk before the LEFT MSB (with I2S_LEFT_JUSTIFIED_EN: coincident with the MSB).
- Hold s_valid=0 across one frame boundary → par_word=0 in both slots, underrun=1, frame timing unchanged. Then underrun_clr=1 with no new underrun → underrun=0.
- Set sample_size=0, s_left=0x000000A5 → par_word=0xA5000000. Set sample_size=7 (invalid) → data handled as 16b.
- Deassert enable at LEFT bit_idx=5 → RIGHT slot completes, then IDLE, busy=0, s_ready=0. Assert rst mid-RIGHT → next cycle all outputs are at reset values.
